booth_sequencer: RTL and testbench
==================================

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the signed operand width.
REQ-002 The block SHALL have parameter DIN_W, default 14, giving the multiplier data_in bus width (DIN_W >= W).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles before abort.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports op_valid (input, 1), op_ready (output, 1), op_a (input, W, signed multiplicand) and op_b (input, W, signed multiplier).
REQ-007 The block SHALL have ports mul_start (output, 1), mul_data (output, DIN_W, multiplier data_in), mul_done (input, 1) and mul_prod (input, 2W, multiplier {A,Q}).
REQ-008 The block SHALL have ports res_valid (output, 1), res_ready (input, 1), res_prod (output, 2W) and res_err (output, 1, timeout flag).
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, START, LOAD_M, LOAD_Q, WAIT, OUT.
REQ-011 op_ready SHALL be 1 only in IDLE; the operand handshake is op_valid & op_ready on a rising edge.
REQ-012 On the handshake, op_a and op_b SHALL be registered, and the FSM SHALL move IDLE->START.
REQ-013 In START (1 cycle), mul_start=1 and mul_data=0; next state LOAD_M.
REQ-014 In LOAD_M (1 cycle), mul_data SHALL be op_a sign-extended to DIN_W; next state LOAD_Q.
REQ-015 In LOAD_Q (1 cycle), mul_data SHALL be op_b sign-extended to DIN_W; next state WAIT.
REQ-016 mul_start SHALL be 0 in every state except START, and mul_data SHALL be 0 in all states other than LOAD_M and LOAD_Q.
REQ-017 In WAIT, a watchdog counter SHALL increment each cycle starting at 0.
REQ-018 In WAIT, on the first cycle with mul_done=1, res_prod SHALL capture mul_prod, res_err SHALL be 0, and the FSM SHALL go to OUT.
REQ-019 If the counter reaches TIMEOUT-1 with mul_done=0, res_prod SHALL be 0, res_err SHALL be 1, and the FSM SHALL go to OUT.
REQ-020 If mul_done=1 on the timeout cycle, done SHALL take priority (REQ-018).
REQ-021 In OUT, res_valid SHALL be 1, and res_prod and res_err SHALL be held stable until res_valid & res_ready, then the FSM SHALL go to IDLE.
REQ-022 mul_done SHALL be ignored in every state except WAIT.
REQ-023 Minimum latency from handshake to res_valid SHALL be 4 cycles (START, LOAD_M, LOAD_Q, first WAIT cycle with done).
REQ-024 With res_ready held at 1, the throughput SHALL be one operation per (multiplier latency + 5) cycles; no new operand is accepted in the OUT->IDLE transition cycle.

Reset
REQ-025 Asserting rst_n=0 at any time, including mid-WAIT, SHALL immediately force state IDLE, counter 0, and op_a/op_b/res_prod 0.
REQ-026 While rst_n=0, outputs SHALL be mul_start=0, mul_data=0, res_valid=0, res_err=0, busy=0 and op_ready=0.
REQ-027 op_ready SHALL become 1 on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package booth_pkg SHALL hold the state encoding, the default W, DIN_W and TIMEOUT constants, and the sign-extension function.
REQ-029 The watchdog SHALL be sub-module booth_wdog (inputs clr and en; output expired), instantiated once.
REQ-030 The FSM, operand registers and result register SHALL stay in booth_sequencer.

Verification
REQ-031 Basic: op_a=5, op_b=8 with a multiplier model returning done after 10 cycles -> mul_data sequence 0,5,8; res_prod=0x0028, res_err=0.
REQ-032 Signed: op_a=-3, op_b=7 -> mul_data in LOAD_M is 0x3FFD; res_prod=0xFFEB.
REQ-033 Backpressure: res_ready low for 20 cycles in OUT -> res_valid and res_prod stable, op_ready=0 throughout, mul_start never reasserted.
REQ-034 Timeout: mul_done never asserted -> res_valid 64 cycles after entering WAIT, res_err=1, res_prod=0; mul_done=1 exactly on the timeout cycle -> res_err=0.
REQ-035 Reset mid-WAIT: rst_n=0 pulsed at WAIT cycle 3 -> immediate IDLE, all outputs at reset values; next op 2*3 -> res_prod=0x0006.
REQ-036 Back-to-back: 4 operand pairs with op_valid held high and res_ready=1 -> 4 correct products in order, exactly one mul_start per pair.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants, FSM state encoding and the sign-extension helper
// used by the Booth multiplier sequencer.
package booth_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_DIN_W   = 14;
  localparam int DEF_TIMEOUT = 64;
  // Widest operand the sign-extension helper can handle.
  localparam int EXT_W       = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD_M,
    ST_LOAD_Q,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Copy bit (width-1) of val into every bit position at or above width.
  function automatic logic [EXT_W-1:0] sign_extend(input logic [EXT_W-1:0] val,
                                                   input int              width);
    logic [EXT_W-1:0] upper_mask;
    logic             sign_bit;
    upper_mask = {EXT_W{1'b1}} << width;
    sign_bit   = |(val & (EXT_W'(1) << (width - 1)));
    return sign_bit ? (val | upper_mask) : (val & ~upper_mask);
  endfunction

endpackage

// File: rtl/booth_sequencer_if.sv
// Operand, multiplier-control and result signals of the Booth sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface booth_sequencer_if
  import booth_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DIN_W = DEF_DIN_W
);

  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;

  logic             mul_start;
  logic [DIN_W-1:0] mul_data;
  logic             mul_done;
  logic [2*W-1:0]   mul_prod;

  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res_prod;
  logic             res_err;

  logic             busy;

  modport master (
    output op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
    input  op_ready, mul_start, mul_data, res_valid, res_prod, res_err, busy
  );

  modport slave (
    input  op_valid, op_a, op_b, mul_done, mul_prod, res_ready,
    output op_ready, mul_start, mul_data, res_valid, res_prod, res_err, busy
  );

endinterface

// File: rtl/booth_wdog.sv
// Watchdog for the WAIT state: counts enabled cycles from 0 and flags the
// cycle on which the count reaches TIMEOUT-1.
module booth_wdog
  import booth_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: cleared outside WAIT, advances once per WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = en & (r_cnt == LAST);

endmodule

// File: rtl/booth_sequencer.sv
// Sequencer that feeds a Booth multiplier: latches an operand pair, drives the
// start/load protocol, waits for done under a watchdog and presents the result.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DIN_W   = DEF_DIN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  booth_sequencer_if.slave  bus
);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_prod;
  logic           r_err;
  // Goes high on the first edge after reset so op_ready stays low during reset.
  logic           r_alive;
  logic           w_in_wait;
  logic           w_accept;
  logic           w_expired;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_accept  = bus.op_valid & bus.op_ready;

  booth_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!w_in_wait),
    .en      (w_in_wait),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch on handshake; result capture on done (wins) or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_a <= bus.op_a;
        r_b <= bus.op_b;
      end
      if (w_in_wait) begin
        if (bus.mul_done) begin
          r_prod <= bus.mul_prod;
          r_err  <= 1'b0;
        end else if (w_expired) begin
          r_prod <= '0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    w_next        = r_state;
    bus.op_ready  = 1'b0;
    bus.mul_start = 1'b0;
    bus.mul_data  = '0;
    bus.res_valid = 1'b0;
    bus.busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        bus.op_ready = r_alive;
        if (bus.op_valid && r_alive) w_next = ST_START;
      end
      ST_START: begin
        bus.mul_start = 1'b1;
        w_next        = ST_LOAD_M;
      end
      ST_LOAD_M: begin
        bus.mul_data = DIN_W'(sign_extend(EXT_W'(r_a), W));
        w_next       = ST_LOAD_Q;
      end
      ST_LOAD_Q: begin
        bus.mul_data = DIN_W'(sign_extend(EXT_W'(r_b), W));
        w_next       = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mul_done || w_expired) w_next = ST_OUT;
      end
      ST_OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.res_prod = r_prod;
  assign bus.res_err  = r_err;

endmodule

// File: tb/tb_booth_sequencer.sv
// Randomized self-checking bench for booth_sequencer. Expected outputs for each
// cycle are derived from the cycle offset since the operand handshake.
module tb_booth_sequencer;

  localparam int W       = 8;
  localparam int DIN_W   = 14;
  localparam int TIMEOUT = 64;
  localparam int PW      = 2 * W;
  localparam int T_WAIT0 = 4;                      // offset of first WAIT cycle
  localparam int T_LAST  = T_WAIT0 + TIMEOUT - 1;  // offset of last WAIT cycle

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  booth_sequencer_if #(.W(W), .DIN_W(DIN_W)) bus ();

  booth_sequencer #(.W(W), .DIN_W(DIN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic             chk_en = 1'b0;
  logic             e_ready, e_busy, e_start, e_valid, e_err;
  logic [DIN_W-1:0] e_data;
  logic [PW-1:0]    e_prod;

  logic [DIN_W-1:0] sm;
  logic [PW-1:0]    sp;
  logic             se;

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [DIN_W-1:0] ref_sext(input logic [W-1:0] v);
    logic signed [DIN_W-1:0] s;
    s = $signed(v);
    return s;
  endfunction

  task automatic set_reset_expect();
    e_ready = 1'b0; e_busy = 1'b0; e_start = 1'b0; e_valid = 1'b0;
    e_err   = 1'b0; e_data = '0;   e_prod  = '0;
  endtask

  // Compare every DUT output against the expectation for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("op_ready",  64'(bus.op_ready),  64'(e_ready));
      check1("busy",      64'(bus.busy),      64'(e_busy));
      check1("mul_start", 64'(bus.mul_start), 64'(e_start));
      check1("mul_data",  64'(bus.mul_data),  64'(e_data));
      check1("res_valid", 64'(bus.res_valid), 64'(e_valid));
      check1("res_prod",  64'(bus.res_prod),  64'(e_prod));
      check1("res_err",   64'(bus.res_err),   64'(e_err));
    end
  end

  // One operation. Entered and left at posedge+1 of an IDLE cycle (t=0).
  // done_t: offset at which the multiplier stub pulses done (outside WAIT the
  // done line is random noise); hold: OUT cycles with res_ready low;
  // rst_at: offset at which reset is pulsed (0 = never).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int done_t, input int hold, input int rst_at,
                        input logic keep_valid,
                        output logic [DIN_W-1:0] seen_m,
                        output logic [PW-1:0] seen_prod, output logic seen_err);
    logic          ok_done;
    int            t_out;
    logic [PW-1:0] p;
    ok_done   = (done_t >= T_WAIT0) && (done_t <= T_LAST);
    t_out     = ok_done ? done_t + 1 : T_LAST + 1;
    p         = ref_prod(a, b);
    seen_m    = '0;
    seen_prod = '0;
    seen_err  = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      bus.op_valid  = (t == 0 || keep_valid) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.op_a      = (t == 0) ? a : W'($urandom);
      bus.op_b      = (t == 0) ? b : W'($urandom);
      if (t >= T_WAIT0 && t < t_out) bus.mul_done = (t == done_t);
      else                           bus.mul_done = 1'($urandom_range(0, 1));
      bus.mul_prod  = (t == done_t) ? p : PW'($urandom);
      bus.res_ready = (t >= t_out) ? (t - t_out >= hold) : 1'($urandom_range(0, 1));
      e_ready = (t == 0);
      e_busy  = (t != 0);
      e_start = (t == 1);
      e_data  = (t == 2) ? ref_sext(a) : (t == 3) ? ref_sext(b) : '0;
      e_valid = (t >= t_out);
      if (t == t_out) begin
        e_prod = ok_done ? p : '0;
        e_err  = !ok_done;
      end
      if (t == 2) seen_m = bus.mul_data;
      if (t == t_out) begin
        seen_prod = bus.res_prod;
        seen_err  = bus.res_err;
      end
      if (rst_at != 0 && t == rst_at) begin
        #1;
        rst_n = 1'b0;
        set_reset_expect();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.op_valid = 1'b1;
        bus.mul_done = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        $display("op a=%0d b=%0d aborted by reset at offset %0d", $signed(a), $signed(b), t);
        return;
      end
      @(posedge clk);
      #1;
      if (t >= t_out && (t - t_out) >= hold) break;
    end
    $display("op a=%0d b=%0d done_t=%0d hold=%0d -> prod=%h err=%0d",
             $signed(a), $signed(b), done_t, hold, seen_prod, seen_err);
  endtask

  initial begin
    int dt, hold, r;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.mul_done = 1'b0; bus.mul_prod = '0; bus.res_ready = 1'b0;
    set_reset_expect();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;   // op_ready must still be low this cycle
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 5*8, done 10 cycles after start.
    run_op(8'd5, 8'd8, 11, 0, 0, 1'b0, sm, sp, se);
    check1("basic_load_m", 64'(sm), 64'h5);
    check1("basic_prod",   64'(sp), 64'h0028);
    check1("basic_err",    64'(se), 64'h0);

    // Signed: -3*7.
    run_op(8'hFD, 8'd7, 6, 0, 0, 1'b0, sm, sp, se);
    check1("signed_load_m", 64'(sm), 64'h3FFD);
    check1("signed_prod",   64'(sp), 64'hFFEB);

    // Minimum latency and backpressure in OUT.
    run_op(8'd12, 8'hF0, T_WAIT0, 20, 0, 1'b0, sm, sp, se);
    check1("bp_prod", 64'(sp), 64'hFF40);

    // Timeout, then done exactly on the timeout cycle, then one cycle late.
    run_op(8'd9, 8'd9, 0, 2, 0, 1'b0, sm, sp, se);
    check1("to_prod", 64'(sp), 64'h0);
    check1("to_err",  64'(se), 64'h1);
    run_op(8'd4, 8'hFE, T_LAST, 0, 0, 1'b0, sm, sp, se);
    check1("to_edge_prod", 64'(sp), 64'hFFF8);
    check1("to_edge_err",  64'(se), 64'h0);
    run_op(8'd3, 8'd3, T_LAST + 1, 0, 0, 1'b0, sm, sp, se);
    check1("to_late_err", 64'(se), 64'h1);

    // Reset at WAIT cycle 3, then 2*3.
    run_op(8'd9, 8'd11, 0, 0, T_WAIT0 + 3, 1'b0, sm, sp, se);
    run_op(8'd2, 8'd3, 5, 0, 0, 1'b0, sm, sp, se);
    check1("post_rst_prod", 64'(sp), 64'h0006);

    // Back-to-back with op_valid held high.
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), $urandom_range(T_WAIT0, T_WAIT0 + 6), 0, 0,
             1'b1, sm, sp, se);
    end

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      dt = 0;
      else if (r == 1) dt = T_LAST;
      else             dt = $urandom_range(T_WAIT0, T_WAIT0 + 12);
      hold = $urandom_range(0, 3);
      run_op(W'($urandom), W'($urandom), dt, hold, 0, 1'($urandom_range(0, 1)), sm, sp, se);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
